// File: rtl/word_unpack_pkg.sv
// word_unpack_pkg: shared types and constants for the word_unpack byte reader.
//   BYTES_PER_WORD : bytes in a 32-bit word
//   byte_idx_t     : 2-bit byte index (0 = bits 7:0 ... 3 = bits 31:24)
//   state_t        : FSM encoding, IDLE = 0, SEND = 1
package word_unpack_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef logic [1:0] byte_idx_t;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/word_unpack_getb.sv
// word_unpack_getb: combinational get-byte, inverse of the byte-insert path.
//   word : 32-bit source word
//   idx  : byte index to extract
//   b    : word[8*idx+7 : 8*idx]
module word_unpack_getb
    import word_unpack_pkg::*;
(
    input  logic [31:0] word,
    input  byte_idx_t   idx,
    output logic [7:0]  b
);
    assign b = word[8*idx +: 8];
endmodule

// File: rtl/word_unpack.sv
// word_unpack: accepts a 32-bit word with start index and byte count, streams the
// selected bytes one per handshake.
//   clk, reset                      : clock, async active-high reset
//   in_valid/in_ready               : word request handshake
//   in_word, in_first, in_count     : word, first byte index, byte count minus 1
//   out_valid/out_ready             : byte stream handshake
//   out_byte, out_idx, out_last     : byte, its index in the word, final-byte flag
//   busy                            : high while a word is being sent
module word_unpack
    import word_unpack_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  byte_idx_t        in_first,
    input  logic [1:0]       in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output byte_idx_t        out_idx,
    output logic             out_last,
    output logic             busy
);
    state_t          state, state_n;
    logic [WIDTH-1:0] word_q;
    byte_idx_t       idx_q;
    logic [1:0]      rem_q;
    logic            accept, fire, done;

    assign fire   = out_valid && out_ready;
    assign done   = fire && out_last;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            word_q <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                word_q <= in_word;
                idx_q  <= in_first;
                rem_q  <= in_count;
            end else if (fire && !out_last) begin
                idx_q <= idx_q + 2'd1;
                rem_q <= rem_q - 2'd1;
            end
        end
    end

    // A new accept on the last byte's handshake reloads without a bubble.
    always_comb begin
        state_n = accept ? SEND : done ? IDLE : state;
    end

    always_comb begin
        out_valid = state == SEND;
        busy      = state == SEND;
        out_last  = state == SEND && rem_q == 2'd0;
        out_idx   = idx_q;
        in_ready  = state == IDLE || done;
    end

    word_unpack_getb u_getb (
        .word (word_q),
        .idx  (idx_q),
        .b    (out_byte)
    );
endmodule

// File: tb/tb_word_unpack.sv
// tb_word_unpack: directed self-checking bench for word_unpack.
module tb_word_unpack;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic [1:0]  in_first = '0;
    logic [1:0]  in_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    word_unpack dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_first  (in_first),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [1:0] f, input logic [1:0] c);
        in_valid = 1'b1;
        in_word  = w;
        in_first = f;
        in_count = c;
        #1;
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic exp_byte(input string tag, input logic rdy, input logic [7:0] b,
                            input logic [1:0] i, input logic last);
        out_ready = rdy;
        #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_byte"}, out_byte, b);
        check({tag, "_idx"}, out_idx, i);
        check({tag, "_last"}, out_last, last);
        check({tag, "_in_ready"}, in_ready, last && rdy);
        tick();
    endtask

    task automatic exp_idle(input string tag);
        #1;
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_last", out_last, 0);
        check("rst_byte", out_byte, 0);
        check("rst_idx", out_idx, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        tick();

        send(32'h44332211, 2'd0, 2'd3);
        exp_byte("w1b0", 1, 8'h11, 2'd0, 0);
        exp_byte("w1b1", 1, 8'h22, 2'd1, 0);
        exp_byte("w1b2", 1, 8'h33, 2'd2, 0);
        exp_byte("w1b3", 1, 8'h44, 2'd3, 1);
        exp_idle("w1_end");

        send(32'hDDCCBBAA, 2'd3, 2'd2);
        exp_byte("wrap0", 1, 8'hDD, 2'd3, 0);
        exp_byte("wrap1", 1, 8'hAA, 2'd0, 0);
        exp_byte("wrap2", 1, 8'hBB, 2'd1, 1);
        exp_idle("wrap_end");

        send(32'h0A0B0C0D, 2'd1, 2'd1);
        exp_byte("bp0", 0, 8'h0C, 2'd1, 0);
        exp_byte("bp1", 0, 8'h0C, 2'd1, 0);
        exp_byte("bp2", 1, 8'h0C, 2'd1, 0);
        exp_byte("bp3", 1, 8'h0B, 2'd2, 1);
        exp_idle("bp_end");

        in_valid = 1'b1;
        in_word  = 32'h11111111;
        in_first = 2'd0;
        in_count = 2'd0;
        tick();
        in_word = 32'h22222222;
        exp_byte("b2b0", 1, 8'h11, 2'd0, 1);
        in_valid = 1'b0;
        exp_byte("b2b1", 1, 8'h22, 2'd0, 1);
        exp_idle("b2b_end");

        send(32'h44332211, 2'd0, 2'd3);
        exp_byte("ar0", 1, 8'h11, 2'd0, 0);
        exp_byte("ar1", 1, 8'h22, 2'd1, 0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_busy", busy, 0);
        tick();
        reset = 1'b0;
        exp_idle("ar_rel0");
        tick();
        exp_idle("ar_rel1");
        tick();

        send(32'h00FF0000, 2'd2, 2'd0);
        exp_byte("one", 1, 8'hFF, 2'd2, 1);
        exp_idle("one_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
